// File: rtl/ddr_pkg.sv
// Shared definitions for the level sequencer and its neighbours: note terminator,
// arrow-lane bit positions and the sequencer state encoding.
package ddr_pkg;

  localparam logic [3:0] NOTE_END = 4'b1111;

  localparam int unsigned LANE_L = 3;
  localparam int unsigned LANE_D = 2;
  localparam int unsigned LANE_U = 1;
  localparam int unsigned LANE_R = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LATCH     = 3'd2,
    ST_WAIT_BEAT = 3'd3,
    ST_DONE      = 3'd4
  } seq_state_e;

endpackage

// File: rtl/level_sequencer_beat_timer.sv
// Free-running beat counter with synchronous clear and enable; tick_c flags the
// last cycle of each beat so the consumer acts on the same edge the count wraps.
module beat_timer #(
  parameter int unsigned BEAT_CYCLES = 25000000,
  parameter int unsigned CNT_WIDTH   = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_c
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BEAT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  assign tick_c = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_c ? '0 : cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Walks a level's note chart out of a synchronous ROM and issues one note per beat
// until the end-of-level terminator or the last ROM address is reached.
module level_sequencer
  import ddr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned BEAT_CYCLES = 25000000,
  parameter int unsigned CNT_WIDTH   = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pause,
  input  logic [DATA_WIDTH-1:0] rom_note,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [DATA_WIDTH-1:0] note,
  output logic                  note_valid,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] note_count
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [DATA_WIDTH-1:0] END_WORD  = DATA_WIDTH'(NOTE_END);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0] note_reg_q, note_reg_d;
  logic [DATA_WIDTH-1:0] note_q, note_d;
  logic                  note_valid_q, note_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_pend_q, done_pend_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] note_count_q, note_count_d;

  logic timer_clr_c;
  logic timer_en_c;
  logic beat_tick_c;

  assign timer_en_c = busy_q && !pause;

  beat_timer #(
    .BEAT_CYCLES(BEAT_CYCLES),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_beat_timer (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (timer_clr_c),
    .en_i  (timer_en_c),
    .tick_c(beat_tick_c)
  );

  // Next-state and registered-output logic; done is delayed one cycle past DONE entry.
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    note_reg_d   = note_reg_q;
    note_d       = note_q;
    note_valid_d = 1'b0;
    note_count_d = note_count_q;
    done_pend_d  = 1'b0;
    done_d       = done_pend_q;
    timer_clr_c  = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      timer_clr_c = 1'b1;
      done_d      = 1'b0;
    end else if (!pause) begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d      = ST_FETCH;
            rom_addr_d   = '0;
            note_count_d = '0;
            timer_clr_c  = 1'b1;
          end
        end
        ST_FETCH: state_d = ST_LATCH;
        ST_LATCH: begin
          note_reg_d = rom_note;
          if (rom_note == END_WORD) begin
            state_d     = ST_DONE;
            done_pend_d = 1'b1;
          end else begin
            state_d = ST_WAIT_BEAT;
          end
        end
        ST_WAIT_BEAT: begin
          if (beat_tick_c) begin
            note_d       = note_reg_q;
            note_valid_d = 1'b1;
            note_count_d = note_count_q + ADDR_WIDTH'(1);
            if (rom_addr_q == ADDR_LAST) begin
              state_d     = ST_DONE;
              done_pend_d = 1'b1;
            end else begin
              state_d    = ST_FETCH;
              rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rom_addr_q   <= '0;
      note_reg_q   <= '0;
      note_q       <= '0;
      note_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_pend_q  <= 1'b0;
      done_q       <= 1'b0;
      note_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      note_reg_q   <= note_reg_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      busy_q       <= busy_d;
      done_pend_q  <= done_pend_d;
      done_q       <= done_d;
      note_count_q <= note_count_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign note       = note_q;
  assign note_valid = note_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign note_count = note_count_q;

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
Reads one level's note chart out of a synchronous level ROM and issues the notes to the arrow-spawn logic, one note per beat. It walks ROM addresses from 0, absorbs the ROM's 1-cycle read latency, and stops on the 4'b1111 end-of-level terminator or at the last address. It sits between the level ROMs (through the level-select mux) and the arrow scroller/score logic.

Parameters:
ADDR_WIDTH, 6, ROM address width; must match the level ROM.
DATA_WIDTH, 4, note width; one bit per arrow lane, {left, down, up, right}.
BEAT_CYCLES, 25000000, clock cycles per beat; must be >= 4.
CNT_WIDTH, 25, beat counter width; must satisfy 2^CNT_WIDTH > BEAT_CYCLES.

Ports:
clk  in  1  system clock; all state changes on posedge clk.
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse that begins the level; honoured only in IDLE.
abort  in  1  level-level; returns to IDLE from any state.
pause  in  1  level-level; freezes the beat counter and the FSM.
rom_note  in  DATA_WIDTH  ROM data, valid 1 cycle after rom_addr is sampled.
rom_addr  out  ADDR_WIDTH  ROM read address.
note  out  DATA_WIDTH  current note; valid while note_valid is high.
note_valid  out  1  one-cycle pulse per emitted note.
busy  out  1  high in every state except IDLE and DONE.
done  out  1  one-cycle pulse when the level ends.
note_count  out  ADDR_WIDTH  number of notes emitted since start.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rom_addr=0, note=0, note_valid=0, done=0, busy=0, note_count=0, beat_cnt=0.
- States: IDLE, FETCH, LATCH, WAIT_BEAT, DONE.
- IDLE: when start=1, set rom_addr=0, beat_cnt=0, note_count=0, and go to FETCH.
- FETCH: hold rom_addr for one cycle so the ROM can register it; go to LATCH.
- LATCH: rom_note is valid in this cycle. Capture it into note_reg.
  - If rom_note==4'b1111: pulse done next cycle and go to DONE. No note_valid is issued for the terminator.
  - Otherwise go to WAIT_BEAT.
- Beat counter:
  - Runs from the cycle after start whenever busy=1 and pause=0.
  - beat_tick = (beat_cnt==BEAT_CYCLES-1), then beat_cnt wraps to 0.
  - BEAT_CYCLES >= 4 guarantees FETCH and LATCH finish before the next tick.
- WAIT_BEAT: on beat_tick:
  - register note=note_reg and note_valid=1 for exactly one cycle;
  - increment note_count;
  - if rom_addr==2^ADDR_WIDTH-1, pulse done and go to DONE (address never wraps);
  - otherwise increment rom_addr and go to FETCH.
- Note timing: the first note_valid appears BEAT_CYCLES+1 cycles after the start edge. Later notes follow every BEAT_CYCLES cycles exactly.
- DONE: busy=0. The state stays in DONE until start, which restarts the level exactly as from IDLE.
- pause=1: beat_cnt, state, rom_addr and note_count all hold, and note_valid is forced to 0. On release, timing resumes from the frozen count; no beat is lost or duplicated.
- abort=1: go to IDLE next cycle. Clear note_valid and beat_cnt; no done pulse. abort has priority over pause and start.
- start while busy: ignored.
- note retains its last emitted value between pulses. note is 0 after reset.
- Reset mid-level behaves exactly like power-up.
- ROM reset tie-off: at top level the ROM's active-high reset is driven by ~rst.

Decomposition:
- Shared package ddr_pkg holds:
  - NOTE_END = 4'b1111;
  - lane bit constants LANE_L=3, LANE_D=2, LANE_U=1, LANE_R=0;
  - the state encoding typedef for IDLE/FETCH/LATCH/WAIT_BEAT/DONE.
- One natural sub-module: beat_timer. It holds the parameterised BEAT_CYCLES counter with clear, enable and tick output, and it is reusable by the scroller.

Test Plan:
1. BEAT_CYCLES=4, ROM {0100,1000,0001,1111}, start at cycle 0 -> note_valid at cycles 5, 9, 13 with note 0100, 1000, 0001; done pulse at cycle 16; note_count=3; busy=0 afterwards.
2. ROM word 0 = 1111, start -> no note_valid; done pulses once; note_count=0.
3. ROM with no terminator (ADDR_WIDTH=2, all words 0010) -> exactly 4 note_valid pulses; done follows the 4th pulse; rom_addr stays at 3 (no wrap).
4. Same setup as test 1 with pause high for cycles 6-15 -> second note_valid moves from 9 to 19; no pulse occurs while pause is high.
5. Same setup as test 1 with abort at cycle 7 -> IDLE at cycle 8; no further note_valid or done; a start at cycle 10 gives first note_valid at cycle 15 with note 0100.
6. rst low at cycle 11 during test 1 -> all outputs read 0 immediately (asynchronous); they stay 0 and the state stays IDLE until a new start after release.
